// File: rtl/lisnoc_packetizer_pkg.sv
// Shared flit-type encodings, FSM states and header field positions for the packetizer.
package lisnoc_packetizer_pkg;

  typedef enum logic [1:0] {
    FLIT_PAYLOAD = 2'b00,
    FLIT_HEADER  = 2'b01,
    FLIT_LAST    = 2'b10,
    FLIT_SINGLE  = 2'b11
  } flit_type_e;

  typedef enum logic {
    ST_HDR  = 1'b0,
    ST_BODY = 1'b1
  } state_e;

  // Header: destination in the top ph_dest_width data bits, continuation flag in bit 0.
  localparam int unsigned HDR_CONT_BIT = 0;

endpackage

// File: rtl/lisnoc_packetizer_if.sv
// Message-stream input and single-VC flit output of the packetizer, grouped as one bus.
interface lisnoc_packetizer_if #(
  parameter int flit_data_width = 32,
  parameter int flit_type_width = 2,
  parameter int ph_dest_width   = 5,
  parameter int vchannels       = 1
);
  localparam int flit_width = flit_data_width + flit_type_width;

  logic [flit_data_width-1:0] in_data_i;
  logic                       in_last_i;
  logic [ph_dest_width-1:0]   in_dest_i;
  logic                       in_valid_i;
  logic                       in_ready_o;
  logic [flit_width-1:0]      out_flit_o;
  logic [vchannels-1:0]       out_valid_o;
  logic [vchannels-1:0]       out_ready_i;

  modport slave (
    input  in_data_i, in_last_i, in_dest_i, in_valid_i, out_ready_i,
    output in_ready_o, out_flit_o, out_valid_o
  );

  modport master (
    output in_data_i, in_last_i, in_dest_i, in_valid_i, out_ready_i,
    input  in_ready_o, out_flit_o, out_valid_o
  );

endinterface

// File: rtl/lisnoc_packetizer_outreg.sv
// Single-entry output register: holds flit/valid under backpressure, expands valid onto vc_sel.
module lisnoc_packetizer_outreg #(
  parameter int flit_width = 34,
  parameter int vchannels  = 1,
  parameter int vc_sel     = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_load,
  input  logic [flit_width-1:0] i_flit,
  input  logic [vchannels-1:0]  i_ready,
  output logic [flit_width-1:0] o_flit,
  output logic [vchannels-1:0]  o_valid,
  output logic                  o_slot_free,
  output logic                  o_handshake
);

  logic                  r_valid;
  logic [flit_width-1:0] r_flit;
  logic                  w_ready;

  assign w_ready     = |(i_ready & (vchannels'(1) << vc_sel));
  assign o_slot_free = !r_valid || w_ready;
  assign o_handshake = r_valid && w_ready;
  assign o_flit      = r_flit;

  always_comb begin
    o_valid         = '0;
    o_valid[vc_sel] = r_valid;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_flit  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_flit  <= i_flit;
    end else if (w_ready) begin
      r_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/lisnoc_packetizer.sv
// Splits a word stream into lisnoc wormhole packets (HEADER, PAYLOAD..., LAST) on one VC,
// opening a continuation packet whenever max_payload words have been sent.
module lisnoc_packetizer
  import lisnoc_packetizer_pkg::*;
#(
  parameter int flit_data_width = 32,
  parameter int flit_type_width = 2,
  parameter int ph_dest_width   = 5,
  parameter int vchannels       = 1,
  parameter int vc_sel          = 0,
  parameter int max_payload     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  lisnoc_packetizer_if.slave   bus,
  output logic [15:0]          pkt_count_o
);

  localparam int flit_width = flit_data_width + flit_type_width;
  localparam int CNT_W      = (max_payload > 1) ? $clog2(max_payload) : 1;

  state_e                     r_state;
  logic                       r_cont;
  logic [CNT_W-1:0]           r_cnt;
  logic [ph_dest_width-1:0]   r_dest_q;
  logic [15:0]                r_pkt_count;

  logic                       w_slot_free;
  logic                       w_handshake;
  logic                       w_hdr_fire;
  logic                       w_word_fire;
  logic                       w_at_limit;
  logic                       w_load;
  logic [flit_width-1:0]      w_flit;
  logic [flit_data_width-1:0] w_hdr_data;
  logic [ph_dest_width-1:0]   w_hdr_dest;
  logic [flit_type_width-1:0] w_out_type;

  assign w_hdr_fire     = (r_state == ST_HDR) && (bus.in_valid_i || r_cont) && w_slot_free;
  assign w_word_fire    = (r_state == ST_BODY) && bus.in_valid_i && w_slot_free;
  assign w_at_limit     = (r_cnt == CNT_W'(max_payload - 1));
  assign w_load         = w_hdr_fire || w_word_fire;
  assign bus.in_ready_o = (r_state == ST_BODY) && w_slot_free;
  assign w_out_type     = bus.out_flit_o[flit_width-1 -: flit_type_width];
  assign pkt_count_o    = r_pkt_count;

  always_comb begin
    w_hdr_dest = r_cont ? r_dest_q : bus.in_dest_i;
    w_hdr_data = '0;
    w_hdr_data[flit_data_width-1 -: ph_dest_width] = w_hdr_dest;
    w_hdr_data[HDR_CONT_BIT] = r_cont;
    if (w_hdr_fire) begin
      w_flit = {flit_type_width'(FLIT_HEADER), w_hdr_data};
    end else if (bus.in_last_i || w_at_limit) begin
      w_flit = {flit_type_width'(FLIT_LAST), bus.in_data_i};
    end else begin
      w_flit = {flit_type_width'(FLIT_PAYLOAD), bus.in_data_i};
    end
  end

  lisnoc_packetizer_outreg #(
    .flit_width (flit_width),
    .vchannels  (vchannels),
    .vc_sel     (vc_sel)
  ) u_outreg (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_load),
    .i_flit      (w_flit),
    .i_ready     (bus.out_ready_i),
    .o_flit      (bus.out_flit_o),
    .o_valid     (bus.out_valid_o),
    .o_slot_free (w_slot_free),
    .o_handshake (w_handshake)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= ST_HDR;
      r_cont      <= 1'b0;
      r_cnt       <= '0;
      r_dest_q    <= '0;
      r_pkt_count <= '0;
    end else begin
      if (w_handshake && (w_out_type == flit_type_width'(FLIT_LAST))) begin
        r_pkt_count <= r_pkt_count + 16'd1;
      end
      case (r_state)
        ST_HDR: begin
          if (w_hdr_fire) begin
            if (!r_cont) begin
              r_dest_q <= bus.in_dest_i;
            end
            r_cnt   <= '0;
            r_state <= ST_BODY;
          end
        end
        ST_BODY: begin
          if (w_word_fire) begin
            if (bus.in_last_i) begin
              r_cont  <= 1'b0;
              r_state <= ST_HDR;
            end else if (w_at_limit) begin
              r_cont  <= 1'b1;
              r_state <= ST_HDR;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        default: r_state <= ST_HDR;
      endcase
    end
  end

endmodule

// File: tb/tb_lisnoc_packetizer.sv
// Directed bench for lisnoc_packetizer (max_payload=4, two VCs, driving VC 1) with a flit scoreboard.
module tb_lisnoc_packetizer;

  localparam int MP = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] pkt_count;

  int errors = 0;
  int checks = 0;
  int n_flits = 0;
  int exp_pkts = 0;

  logic [33:0] sb_q[$];

  always #5 clk = ~clk;

  lisnoc_packetizer_if #(
    .flit_data_width (32),
    .flit_type_width (2),
    .ph_dest_width   (5),
    .vchannels       (2)
  ) bus ();

  lisnoc_packetizer #(
    .flit_data_width (32),
    .flit_type_width (2),
    .ph_dest_width   (5),
    .vchannels       (2),
    .vc_sel          (1),
    .max_payload     (MP)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.slave),
    .pkt_count_o (pkt_count)
  );

  function automatic logic [33:0] hdr_flit(input logic [4:0] dest, input logic cont);
    return {2'b01, dest, 26'd0, cont};
  endfunction

  // Expected flits of a whole message, derived from word count and packet size limit.
  task automatic push_msg(input logic [4:0] dest, input int n, input logic [31:0] base);
    int pos;
    pos = 0;
    for (int i = 0; i < n; i++) begin
      if (pos == 0) sb_q.push_back(hdr_flit(dest, i > 0));
      if (i == n - 1 || pos == MP - 1) begin
        sb_q.push_back({2'b10, base + 32'(i)});
        exp_pkts++;
        pos = 0;
      end else begin
        sb_q.push_back({2'b00, base + 32'(i)});
        pos++;
      end
    end
  endtask

  always @(negedge clk) begin
    logic [33:0] exp;
    if (rst && bus.out_valid_o[1] && bus.out_ready_i[1]) begin
      n_flits++;
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_flit got=%h expected=none", bus.out_flit_o);
      end else begin
        exp = sb_q.pop_front();
        checks++;
        assert (bus.out_flit_o === exp) else begin
          errors++;
          $error("FAIL flit got=%h expected=%h", bus.out_flit_o, exp);
        end
        checks++;
        assert (bus.out_valid_o[0] === 1'b0) else begin
          errors++;
          $error("FAIL other_vc_valid got=%b expected=0", bus.out_valid_o[0]);
        end
      end
    end
  end

  task automatic send_word(input logic [31:0] d, input logic last, input logic [4:0] dest);
    int  t;
    logic hit;
    bus.in_data_i  = d;
    bus.in_last_i  = last;
    bus.in_dest_i  = dest;
    bus.in_valid_i = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      hit = bus.in_ready_o;
      @(posedge clk);
      #1;
      t++;
    end while (!hit && t < 200);
    if (!hit) begin
      checks++;
      errors++;
      $error("FAIL accept_timeout got=no_ready expected=ready word=%h", d);
    end
  endtask

  task automatic send_msg(input logic [4:0] dest, input int n, input logic [31:0] base,
                          input int chg_at, input logic [4:0] dest2);
    push_msg(dest, n, base);
    for (int i = 0; i < n; i++) begin
      send_word(base + 32'(i), i == n - 1, (chg_at >= 0 && i >= chg_at) ? dest2 : dest);
    end
    bus.in_valid_i = 1'b0;
    bus.in_last_i  = 1'b0;
  endtask

  task automatic drain_and_check(input string tag);
    int t;
    t = 0;
    while (sb_q.size() != 0 && t < 500) begin
      @(posedge clk);
      t++;
    end
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $error("FAIL %s_drain got=%0d pending expected=0", tag, sb_q.size());
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    assert (pkt_count === 16'(exp_pkts)) else begin
      errors++;
      $error("FAIL %s_pkt_count got=%0d expected=%0d", tag, pkt_count, exp_pkts);
    end
  endtask

  initial begin
    int f0;
    logic [33:0] held;

    bus.in_data_i   = 32'hDEAD_BEEF;
    bus.in_last_i   = 1'b0;
    bus.in_dest_i   = 5'd4;
    bus.in_valid_i  = 1'b1;
    bus.out_ready_i = 2'b11;

    // Reset held with valid input present
    repeat (3) @(posedge clk);
    #1;
    checks++;
    assert (bus.out_valid_o === 2'b00) else begin
      errors++; $error("FAIL reset_valid got=%b expected=00", bus.out_valid_o);
    end
    checks++;
    assert (bus.in_ready_o === 1'b0) else begin
      errors++; $error("FAIL reset_in_ready got=%b expected=0", bus.in_ready_o);
    end
    checks++;
    assert (pkt_count === 16'd0) else begin
      errors++; $error("FAIL reset_pkt_count got=%0d expected=0", pkt_count);
    end
    checks++;
    assert (bus.out_flit_o === 34'd0) else begin
      errors++; $error("FAIL reset_flit got=%h expected=0", bus.out_flit_o);
    end
    bus.in_valid_i = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;

    // 3-word message to dest 5
    checks++;
    assert (hdr_flit(5'd5, 1'b0) === {2'b01, 32'h2800_0000}) else begin
      errors++; $error("FAIL hdr_layout got=%h expected=%h", hdr_flit(5'd5, 1'b0), {2'b01, 32'h2800_0000});
    end
    send_msg(5'd5, 3, 32'hA, -1, 5'd0);
    drain_and_check("msg3");

    // 10 words to dest 3: three packets, 13 flits
    f0 = n_flits;
    send_msg(5'd3, 10, 32'h100, -1, 5'd0);
    drain_and_check("msg10");
    checks++;
    assert (n_flits - f0 === 13) else begin
      errors++; $error("FAIL msg10_flits got=%0d expected=13", n_flits - f0);
    end

    // Exactly max_payload words: one packet, no empty continuation
    f0 = n_flits;
    send_msg(5'd12, MP, 32'h200, -1, 5'd0);
    drain_and_check("msg_exact");
    checks++;
    assert (n_flits - f0 === MP + 1) else begin
      errors++; $error("FAIL msg_exact_flits got=%0d expected=%0d", n_flits - f0, MP + 1);
    end

    // Backpressure for 4 cycles mid-message
    fork
      send_msg(5'd2, 6, 32'h300, -1, 5'd0);
      begin
        repeat (4) @(posedge clk);
        #1;
        bus.out_ready_i = 2'b01;
        @(negedge clk);
        held = bus.out_flit_o;
        checks++;
        assert (bus.out_valid_o === 2'b10) else begin
          errors++; $error("FAIL bp_valid got=%b expected=10", bus.out_valid_o);
        end
        repeat (4) begin
          @(negedge clk);
          checks++;
          assert (bus.out_flit_o === held) else begin
            errors++; $error("FAIL bp_flit_stable got=%h expected=%h", bus.out_flit_o, held);
          end
          checks++;
          assert (bus.in_ready_o === 1'b0) else begin
            errors++; $error("FAIL bp_in_ready got=%b expected=0", bus.in_ready_o);
          end
        end
        @(posedge clk);
        #1;
        bus.out_ready_i = 2'b11;
      end
    join
    drain_and_check("bp");

    // Destination changes mid-message; continuation header keeps dest 5
    send_msg(5'd5, 6, 32'h400, 2, 5'd9);
    drain_and_check("dest_chg");

    // Reset while a payload flit is held, then a fresh 1-word message
    push_msg(5'd7, 6, 32'h500);
    send_word(32'h500, 1'b0, 5'd7);
    send_word(32'h501, 1'b0, 5'd7);
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 2'b00;
    @(negedge clk);
    checks++;
    assert (bus.out_valid_o === 2'b10) else begin
      errors++; $error("FAIL pre_reset_valid got=%b expected=10", bus.out_valid_o);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    sb_q.delete();
    exp_pkts = 0;
    checks++;
    assert (bus.out_valid_o === 2'b00) else begin
      errors++; $error("FAIL squash_valid got=%b expected=00", bus.out_valid_o);
    end
    checks++;
    assert (pkt_count === 16'd0) else begin
      errors++; $error("FAIL squash_pkt_count got=%0d expected=0", pkt_count);
    end
    rst = 1'b1;
    bus.out_ready_i = 2'b10;
    @(posedge clk);
    #1;
    f0 = n_flits;
    send_msg(5'd1, 1, 32'h55, -1, 5'd0);
    drain_and_check("post_reset");
    checks++;
    assert (n_flits - f0 === 2) else begin
      errors++; $error("FAIL post_reset_flits got=%0d expected=2", n_flits - f0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
